// File: rtl/gfx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gfx_sched_pkg
// Description : Shared types and default sizing for the triangle dispatch
//               scheduler and its round-robin pointer helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gfx_sched_pkg;

  localparam int NUM_TRI_DEF     = 2048;
  localparam int NUM_LANES_DEF   = 4;
  localparam int MEM_LATENCY_DEF = 2;
  localparam int TRI_W_DEF       = $clog2(NUM_TRI_DEF);

  // Issue-side sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    LAUNCH = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

  // Per-lane bookkeeping record at default sizing
  typedef struct packed {
    logic                 busy;
    logic [TRI_W_DEF-1:0] tri_id;
  } lane_state_t;

endpackage
`default_nettype wire

// File: rtl/sched_rr_ptr.sv
`default_nettype none
// ============================================================================
// Module      : sched_rr_ptr
// Description : Modulo-NUM_LANES round-robin pointer with advance enable and
//               synchronous clear. NUM_LANES must be a power of two so the
//               natural binary wrap gives the modulo.
// Revision    : 1.0 - initial release
// ============================================================================
module sched_rr_ptr #(
  parameter  int NUM_LANES = 4,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              clr_in,
  input  logic              adv_in,
  output logic [LANE_W-1:0] ptr_out
);

  logic [LANE_W-1:0] ptr_q;
  logic [LANE_W-1:0] ptr_d;

  // Next pointer: clear wins over advance
  always_comb begin
    ptr_d = ptr_q;
    if (clr_in) begin
      ptr_d = '0;
    end else if (adv_in) begin
      ptr_d = ptr_q + LANE_W'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_out = ptr_q;

endmodule
`default_nettype wire

// File: rtl/tri_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tri_dispatch_scheduler
// Description : Walks one frame of triangles, fetches each from triangle
//               memory, launches them round-robin into parallel lanes and
//               retires lane results strictly in tri_id order. Culled
//               triangles retire silently and are counted.
// Revision    : 1.0 - initial release
// ============================================================================
module tri_dispatch_scheduler
  import gfx_sched_pkg::*;
#(
  parameter  int NUM_TRI     = NUM_TRI_DEF,
  parameter  int NUM_LANES   = NUM_LANES_DEF,
  parameter  int MEM_LATENCY = MEM_LATENCY_DEF,
  localparam int TRI_W       = $clog2(NUM_TRI),
  localparam int LANE_W      = $clog2(NUM_LANES)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 frame_start_in,
  input  logic [TRI_W:0]       num_tri_in,
  output logic                 busy_out,
  output logic                 frame_done_out,
  output logic                 tri_rd_en_out,
  output logic [TRI_W-1:0]     tri_rd_addr_out,
  output logic [NUM_LANES-1:0] lane_valid_out,
  output logic [TRI_W-1:0]     lane_tri_id_out,
  input  logic [NUM_LANES-1:0] lane_ready_in,
  input  logic [NUM_LANES-1:0] lane_done_in,
  input  logic [NUM_LANES-1:0] lane_cull_in,
  output logic [NUM_LANES-1:0] lane_ack_out,
  output logic                 out_valid_out,
  output logic [LANE_W-1:0]    out_lane_sel_out,
  output logic [TRI_W-1:0]     out_tri_id_out,
  input  logic                 out_ready_in,
  output logic [TRI_W:0]       culled_count_out
);

  // Counter spans 0..MEM_LATENCY-1 inside FETCH
  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  sched_state_t         state_q, state_d;
  logic [TRI_W:0]       next_id_q, next_id_d;
  logic [TRI_W:0]       num_tri_q, num_tri_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
  logic [NUM_LANES-1:0] busy_q, busy_d;
  logic [TRI_W-1:0]     tri_id_q [NUM_LANES];
  logic [TRI_W-1:0]     tri_id_d [NUM_LANES];
  logic [TRI_W:0]       culled_q, culled_d;
  logic                 frame_done_q, frame_done_d;

  logic [LANE_W-1:0]    issue_ptr;
  logic [LANE_W-1:0]    retire_ptr;
  logic                 issue_adv;
  logic                 retire_adv;
  logic                 ptr_clr;
  logic                 launch;
  logic                 start_acc;
  logic                 cull_hit;

  sched_rr_ptr #(.NUM_LANES(NUM_LANES)) u_issue_ptr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_in  (ptr_clr),
    .adv_in  (issue_adv),
    .ptr_out (issue_ptr)
  );

  sched_rr_ptr #(.NUM_LANES(NUM_LANES)) u_retire_ptr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_in  (ptr_clr),
    .adv_in  (retire_adv),
    .ptr_out (retire_ptr)
  );

  // Issue FSM: start acceptance, fetch timing, launch gating, drain
  always_comb begin
    state_d        = state_q;
    next_id_d      = next_id_q;
    num_tri_d      = num_tri_q;
    lat_cnt_d      = lat_cnt_q;
    frame_done_d   = 1'b0;
    ptr_clr        = 1'b0;
    issue_adv      = 1'b0;
    launch         = 1'b0;
    start_acc      = 1'b0;
    tri_rd_en_out  = 1'b0;
    lane_valid_out = '0;
    case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          start_acc = 1'b1;
          ptr_clr   = 1'b1;
          next_id_d = '0;
          num_tri_d = num_tri_in;
          lat_cnt_d = '0;
          if (num_tri_in != '0) begin
            state_d = FETCH;
          end else begin
            frame_done_d = 1'b1;
          end
        end
      end
      FETCH: begin
        // Single read strobe on the first FETCH cycle, then wait out the latency
        tri_rd_en_out = (lat_cnt_q == '0);
        if (lat_cnt_q == LAT_W'(MEM_LATENCY - 1)) begin
          state_d = LAUNCH;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      LAUNCH: begin
        // busy_q is the registered flag, so a lane retiring this cycle is
        // only re-launched on the following cycle
        if (!busy_q[issue_ptr] && lane_ready_in[issue_ptr]) begin
          launch                    = 1'b1;
          issue_adv                 = 1'b1;
          lane_valid_out[issue_ptr] = 1'b1;
          next_id_d                 = next_id_q + (TRI_W+1)'(1);
          lat_cnt_d                 = '0;
          if (next_id_q + (TRI_W+1)'(1) == num_tri_q) begin
            state_d = DRAIN;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DRAIN: begin
        if (busy_q == '0) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // In-order retire from the lane at retire_ptr; cull takes precedence
  always_comb begin
    retire_adv    = 1'b0;
    out_valid_out = 1'b0;
    lane_ack_out  = '0;
    cull_hit      = 1'b0;
    if (busy_q[retire_ptr]) begin
      if (lane_cull_in[retire_ptr]) begin
        cull_hit   = 1'b1;
        retire_adv = 1'b1;
      end else if (lane_done_in[retire_ptr]) begin
        out_valid_out = 1'b1;
        if (out_ready_in) begin
          lane_ack_out[retire_ptr] = 1'b1;
          retire_adv               = 1'b1;
        end
      end
    end
  end

  // Lane occupancy, tri_id bookkeeping and cull counter
  always_comb begin
    busy_d   = busy_q;
    tri_id_d = tri_id_q;
    culled_d = culled_q;
    if (retire_adv) begin
      busy_d[retire_ptr] = 1'b0;
    end
    if (launch) begin
      busy_d[issue_ptr]   = 1'b1;
      tri_id_d[issue_ptr] = next_id_q[TRI_W-1:0];
    end
    if (start_acc) begin
      culled_d = '0;
    end else if (cull_hit) begin
      culled_d = culled_q + (TRI_W+1)'(1);
    end
  end

  // State registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      next_id_q    <= '0;
      num_tri_q    <= '0;
      lat_cnt_q    <= '0;
      busy_q       <= '0;
      culled_q     <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        tri_id_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      next_id_q    <= next_id_d;
      num_tri_q    <= num_tri_d;
      lat_cnt_q    <= lat_cnt_d;
      busy_q       <= busy_d;
      culled_q     <= culled_d;
      frame_done_q <= frame_done_d;
      tri_id_q     <= tri_id_d;
    end
  end

  assign busy_out         = (state_q != IDLE);
  assign frame_done_out   = frame_done_q;
  assign tri_rd_addr_out  = next_id_q[TRI_W-1:0];
  assign lane_tri_id_out  = next_id_q[TRI_W-1:0];
  assign out_lane_sel_out = retire_ptr;
  assign out_tri_id_out   = tri_id_q[retire_ptr];
  assign culled_count_out = culled_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_dispatch_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tri_dispatch_scheduler
// Description : Self-checking bench: behavioural lane models, in-order
//               retire scoreboard, vector table plus directed sequences and
//               randomized frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tri_dispatch_scheduler;

  localparam int NL = 4;
  localparam int ML = 2;
  localparam int NT = 2048;
  localparam int TW = 11;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start_in = 1'b0;
  logic [TW:0]   num_tri_in = '0;
  logic          busy_out, frame_done_out, tri_rd_en_out, out_valid_out;
  logic [TW-1:0] tri_rd_addr_out, lane_tri_id_out, out_tri_id_out;
  logic [NL-1:0] lane_valid_out, lane_ack_out;
  logic [NL-1:0] lane_ready_in, lane_done_in, lane_cull_in;
  logic [LW-1:0] out_lane_sel_out;
  logic          out_ready_in;
  logic [TW:0]   culled_count_out;

  always #5 clk = ~clk;

  tri_dispatch_scheduler #(.NUM_TRI(NT), .NUM_LANES(NL), .MEM_LATENCY(ML)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .frame_start_in   (frame_start_in),
    .num_tri_in       (num_tri_in),
    .busy_out         (busy_out),
    .frame_done_out   (frame_done_out),
    .tri_rd_en_out    (tri_rd_en_out),
    .tri_rd_addr_out  (tri_rd_addr_out),
    .lane_valid_out   (lane_valid_out),
    .lane_tri_id_out  (lane_tri_id_out),
    .lane_ready_in    (lane_ready_in),
    .lane_done_in     (lane_done_in),
    .lane_cull_in     (lane_cull_in),
    .lane_ack_out     (lane_ack_out),
    .out_valid_out    (out_valid_out),
    .out_lane_sel_out (out_lane_sel_out),
    .out_tri_id_out   (out_tri_id_out),
    .out_ready_in     (out_ready_in),
    .culled_count_out (culled_count_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame configuration consumed by the lane models
  logic [63:0] cull_mask = '0;
  int          dly_fix [NL];
  bit          rand_dly = 1'b0;
  int          rmode = 0;      // 0: ready always, 1: random, 2: held low

  // Scoreboard state
  int cur_num = 0;
  int exp_rd = 0, exp_launch = 0, exp_oldest = 0;
  int n_out = 0, n_cull = 0, n_done = 0, n_launch = 0, n_rd = 0;
  int cyc = 0, last_rd_cyc = 0;

  // Lane models
  bit lane_has [NL];
  bit lane_dn  [NL];
  int lane_id  [NL];
  int lane_cnt [NL];

  initial begin
    bit            hs, prev_v, prev_hs, culled_one;
    logic [TW-1:0] prev_id;
    logic [NL-1:0] lv, ack, exp_ack;
    int            hs_lane, l_exp, new_id;
    prev_v = 0; prev_hs = 0; prev_id = '0;
    for (int i = 0; i < NL; i++) begin
      lane_has[i] = 0; lane_dn[i] = 0; lane_id[i] = 0; lane_cnt[i] = 0; dly_fix[i] = 1;
    end
    lane_ready_in = '1; lane_done_in = '0; lane_cull_in = '0; out_ready_in = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      lv = lane_valid_out; ack = lane_ack_out;
      hs = out_valid_out && out_ready_in;
      hs_lane = int'(out_lane_sel_out);
      new_id = int'(lane_tri_id_out);
      if (!rst) begin
        if (tri_rd_en_out) begin
          chk(int'(tri_rd_addr_out) == exp_rd, "rd_addr", tri_rd_addr_out, exp_rd);
          exp_rd++; n_rd++; last_rd_cyc = cyc;
        end
        if (lv != '0) begin
          l_exp = exp_launch % NL;
          chk(lv == (NL'(1) << l_exp), "launch_lane", lv, NL'(1) << l_exp);
          chk(new_id == exp_launch, "launch_id", new_id, exp_launch);
          chk(cyc - last_rd_cyc >= ML, "mem_latency", cyc - last_rd_cyc, ML);
          chk(!lane_has[l_exp], "launch_to_busy_lane", lane_has[l_exp], 0);
          exp_launch++; n_launch++;
        end
        if (prev_v && !prev_hs)
          chk(out_valid_out && out_tri_id_out == prev_id, "out_hold",
              {out_valid_out, out_tri_id_out}, {1'b1, prev_id});
        if (hs) begin
          chk(int'(out_tri_id_out) == exp_oldest, "out_order", out_tri_id_out, exp_oldest);
          chk(hs_lane == exp_oldest % NL, "out_lane", hs_lane, exp_oldest % NL);
          chk(int'(out_tri_id_out) < 64 && !cull_mask[out_tri_id_out[5:0]], "out_not_culled",
              out_tri_id_out, 0);
        end
        exp_ack = hs ? (NL'(1) << hs_lane) : '0;
        if (hs || ack != '0) chk(ack == exp_ack, "ack", ack, exp_ack);
        if (frame_done_out) begin
          chk(exp_oldest == cur_num, "done_after_last_retire", exp_oldest, cur_num);
          n_done++;
        end
      end
      prev_v = out_valid_out && !rst; prev_hs = hs; prev_id = out_tri_id_out;

      @(posedge clk); #1;
      lane_cull_in = '0;
      if (rst) begin
        for (int i = 0; i < NL; i++) begin lane_has[i] = 0; lane_dn[i] = 0; end
        prev_v = 0;
      end else begin
        if (hs) begin
          lane_has[hs_lane] = 0; lane_dn[hs_lane] = 0; exp_oldest++; n_out++;
        end
        for (int i = 0; i < NL; i++) begin
          if (lv[i]) begin
            lane_has[i] = 1; lane_dn[i] = 0; lane_id[i] = new_id;
            lane_cnt[i] = rand_dly ? int'($urandom_range(0, 12)) : dly_fix[i];
          end
        end
        culled_one = 0;
        for (int i = 0; i < NL; i++) begin
          if (lane_has[i] && !lane_dn[i]) begin
            if (lane_cnt[i] > 0) begin
              lane_cnt[i]--;
            end else if (lane_id[i] < 64 && cull_mask[lane_id[i]]) begin
              // A cull is only a pulse, so it is offered once the triangle is the oldest
              if (!culled_one && lane_id[i] == exp_oldest) begin
                lane_cull_in[i] = 1'b1; lane_has[i] = 0;
                exp_oldest++; n_cull++; culled_one = 1;
              end
            end else begin
              lane_dn[i] = 1;
            end
          end
        end
      end
      for (int i = 0; i < NL; i++) begin
        lane_done_in[i]  = lane_dn[i];
        lane_ready_in[i] = !lane_has[i];
      end
      out_ready_in = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
    end
  end

  task automatic send_start(input int n);
    @(posedge clk); #2;
    frame_start_in = 1'b1; num_tri_in = (TW+1)'(n);
    @(posedge clk); #2;
    frame_start_in = 1'b0;
  endtask

  task automatic begin_frame(input int n);
    @(posedge clk); #2;
    exp_rd = 0; exp_launch = 0; exp_oldest = 0;
    n_out = 0; n_cull = 0; n_done = 0; n_launch = 0; n_rd = 0; cur_num = n;
    send_start(n);
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (n_done == 0 && c < budget) begin @(posedge clk); c++; end
    chk(n_done != 0, "frame_done_timeout", n_done, 1);
    repeat (6) @(posedge clk);
  endtask

  task automatic end_checks(input int n, input int nout, input int ncull);
    chk(n_done == 1, "done_count", n_done, 1);
    chk(n_out == nout, "out_count", n_out, nout);
    chk(n_cull == ncull, "cull_issued", n_cull, ncull);
    chk(int'(culled_count_out) == ncull, "culled_count", culled_count_out, ncull);
    chk(n_launch == n, "launch_count", n_launch, n);
    chk(n_rd == n, "rd_count", n_rd, n);
    chk(busy_out == 1'b0, "idle_after_frame", busy_out, 0);
  endtask

  typedef struct packed {
    logic [7:0]  num;
    logic [63:0] mask;
    logic [31:0] dly;   // lane3..lane0 delays, 8 bits each
    logic [1:0]  rmode;
    logic [7:0]  exp_nout;
    logic [7:0]  exp_cull;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #900000;
    $display("FAIL watchdog: actual=%0d required=%0d", 0, 1);
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nout, ncull, c;
    vecs[0] = '{num: 8'd5, mask: 64'h0,   dly: 32'h0A0A0A0A, rmode: 2'd0, exp_nout: 8'd5, exp_cull: 8'd0};
    vecs[1] = '{num: 8'd4, mask: 64'h0,   dly: 32'h02020214, rmode: 2'd0, exp_nout: 8'd4, exp_cull: 8'd0};
    vecs[2] = '{num: 8'd6, mask: 64'h12,  dly: 32'h05050505, rmode: 2'd0, exp_nout: 8'd4, exp_cull: 8'd2};
    vecs[3] = '{num: 8'd9, mask: 64'h1FF, dly: 32'h01010101, rmode: 2'd1, exp_nout: 8'd0, exp_cull: 8'd9};
    vecs[4] = '{num: 8'd1, mask: 64'h0,   dly: 32'h00000000, rmode: 2'd1, exp_nout: 8'd1, exp_cull: 8'd0};

    // Reset state
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk(busy_out == 0, "rst_busy", busy_out, 0);
    chk(frame_done_out == 0, "rst_done", frame_done_out, 0);
    chk(tri_rd_en_out == 0, "rst_rd_en", tri_rd_en_out, 0);
    chk(lane_valid_out == 0, "rst_lane_valid", lane_valid_out, 0);
    chk(out_valid_out == 0, "rst_out_valid", out_valid_out, 0);
    chk(lane_ack_out == 0, "rst_ack", lane_ack_out, 0);
    chk(out_tri_id_out == 0, "rst_out_tri_id", out_tri_id_out, 0);
    chk(culled_count_out == 0, "rst_culled", culled_count_out, 0);

    // Vector table
    for (int i = 0; i < 5; i++) begin
      cull_mask = vecs[i].mask;
      for (int l = 0; l < NL; l++) dly_fix[l] = int'(vecs[i].dly[8*l +: 8]);
      rand_dly = 1'b0;
      rmode = int'(vecs[i].rmode);
      begin_frame(int'(vecs[i].num));
      wait_done(2000);
      end_checks(int'(vecs[i].num), int'(vecs[i].exp_nout), int'(vecs[i].exp_cull));
    end

    // Backpressure: output held, no ack, issue stalls with every lane occupied
    cull_mask = '0; rand_dly = 1'b0; rmode = 2;
    for (int l = 0; l < NL; l++) dly_fix[l] = 2;
    begin_frame(6);
    repeat (30) @(posedge clk);
    #2;
    chk(out_valid_out == 1, "bp_valid", out_valid_out, 1);
    chk(out_tri_id_out == 0, "bp_tri_id", out_tri_id_out, 0);
    chk(lane_ack_out == 0, "bp_no_ack", lane_ack_out, 0);
    chk(n_launch == 4, "bp_issue_stall", n_launch, 4);
    chk(n_out == 0, "bp_no_out", n_out, 0);
    rmode = 0;
    wait_done(2000);
    end_checks(6, 6, 0);

    // Empty frame
    begin_frame(0);
    chk(frame_done_out == 1, "zero_done_next_cycle", frame_done_out, 1);
    chk(busy_out == 0, "zero_not_busy", busy_out, 0);
    repeat (5) @(posedge clk);
    end_checks(0, 0, 0);

    // Start while busy is ignored
    for (int l = 0; l < NL; l++) dly_fix[l] = 4;
    begin_frame(3);
    chk(busy_out == 1, "busy_after_start", busy_out, 1);
    repeat (2) @(posedge clk);
    send_start(7);
    wait_done(2000);
    end_checks(3, 3, 0);

    // Asynchronous reset during DRAIN
    for (int l = 0; l < NL; l++) dly_fix[l] = 40;
    begin_frame(2);
    c = 0;
    while (n_launch < 2 && c < 100) begin @(posedge clk); c++; end
    chk(n_launch == 2, "rst_test_launches", n_launch, 2);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk(busy_out == 0, "arst_busy", busy_out, 0);
    chk(out_valid_out == 0 && lane_ack_out == 0, "arst_out", {out_valid_out, lane_ack_out}, 0);
    chk(lane_valid_out == 0 && tri_rd_en_out == 0, "arst_issue", {lane_valid_out, tri_rd_en_out}, 0);
    chk(frame_done_out == 0, "arst_done", frame_done_out, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    chk(n_done == 0, "no_done_after_reset", n_done, 0);
    for (int l = 0; l < NL; l++) dly_fix[l] = 3;
    begin_frame(5);
    wait_done(2000);
    end_checks(5, 5, 0);

    // Randomized frames against the scoreboard
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 40));
      cull_mask = {$urandom, $urandom} & {$urandom, $urandom};
      ncull = 0;
      for (int t = 0; t < n; t++) if (cull_mask[t]) ncull++;
      nout = n - ncull;
      rand_dly = 1'b1;
      rmode = 1;
      begin_frame(n);
      wait_done(3000);
      end_checks(n, nout, ncull);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
